// File: rtl/ring_nic_pkg.sv
// Shared constants for the ring NIC: CPU register map, status word layout
// and packet field positions. Bit 0 is the MSB of every multi-bit vector.
package ring_nic_pkg;

  typedef enum logic [1:0] {
    ADDR_IN_DATA  = 2'b00,
    ADDR_IN_STAT  = 2'b01,
    ADDR_OUT_DATA = 2'b10,
    ADDR_OUT_STAT = 2'b11
  } nic_addr_e;

  localparam int STAT_NONEMPTY = 63;
  localparam int STAT_FULL     = 62;
  localparam int STAT_CNT_LO   = 48;
  localparam int STAT_CNT_HI   = 55;

  localparam int VC_BIT = 0;

endpackage

// File: rtl/nic_fifo.sv
// Small synchronous FIFO used for both NIC directions. Pushes while full and
// pops while empty are ignored; the head reads as zero when nothing is stored.
module nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [0:DATA_WIDTH-1]   push_data,
  input  logic                    pop,
  output logic [0:DATA_WIDTH-1]   head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [0:DATA_WIDTH-1] mem_q [DEPTH];
  logic [0:DATA_WIDTH-1] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state: write at tail, advance head, and track occupancy from pre-edge flags
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset wipes stored data so nothing survives an abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ring_nic.sv
// CPU-side NIC for one ring router node: an ejection FIFO drained by CPU
// reads and an injection FIFO filled by CPU writes, each with a status word.
module ring_nic
  import ring_nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:1]            nicAddr,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic [0:DATA_WIDTH-1] nicDataIn,
  output logic [0:DATA_WIDTH-1] nicDataOut,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [0:DATA_WIDTH-1] in_head, out_head;
  logic [CW-1:0]         in_count, out_count;
  logic                  in_full, in_empty, out_full, out_empty;
  logic                  in_pop, out_push;
  logic                  cpu_rd, cpu_wr;
  nic_addr_e             addr;

  function automatic logic [0:DATA_WIDTH-1] status_word(
    input logic [CW-1:0] cnt,
    input logic          is_full,
    input logic          is_empty
  );
    logic [0:DATA_WIDTH-1] st;
    st = '0;
    st[STAT_CNT_LO:STAT_CNT_HI] = 8'(cnt);
    st[STAT_FULL]               = is_full;
    st[STAT_NONEMPTY]           = ~is_empty;
    return st;
  endfunction

  assign addr   = nic_addr_e'(nicAddr);
  assign cpu_rd = nicEn & ~nicWrEn;
  assign cpu_wr = nicEn & nicWrEn;

  // Decode CPU accesses into FIFO strobes; other addresses have no side effect
  always_comb begin
    in_pop   = 1'b0;
    out_push = 1'b0;
    if (cpu_rd && addr == ADDR_IN_DATA) in_pop = 1'b1;
    if (cpu_wr && addr == ADDR_OUT_DATA) out_push = 1'b1;
  end

  // CPU read mux; writes, idle cycles and reads of the out-data slot return zero
  always_comb begin
    nicDataOut = '0;
    if (cpu_rd) begin
      case (addr)
        ADDR_IN_DATA:  nicDataOut = in_head;
        ADDR_IN_STAT:  nicDataOut = status_word(in_count, in_full, in_empty);
        ADDR_OUT_STAT: nicDataOut = status_word(out_count, out_full, out_empty);
        default:       nicDataOut = '0;
      endcase
    end
  end

  // Head-of-line packet injects only when its VC matches the ring phase
  assign net_ri = ~in_full;
  assign net_do = out_head;
  assign net_so = ~out_empty & net_ro & (out_head[VC_BIT] == net_polarity);

  nic_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (net_si),
    .push_data (net_di),
    .pop       (in_pop),
    .head_data (in_head),
    .count     (in_count),
    .full      (in_full),
    .empty     (in_empty)
  );

  nic_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (out_push),
    .push_data (nicDataIn),
    .pop       (net_so),
    .head_data (out_head),
    .count     (out_count),
    .full      (out_full),
    .empty     (out_empty)
  );

endmodule
